// File: rtl/io_bridge_pkg.sv
// Shared I/O bridge definitions: register offsets, register-select decode and
// the hex-to-cathode table for the 7-segment display.
package io_bridge_pkg;

    localparam logic [7:0]  IO_LED        = 8'h60;
    localparam logic [7:0]  IO_SW         = 8'h70;
    localparam logic [7:0]  IO_SEG_VAL    = 8'h80;
    localparam logic [7:0]  IO_SEG_MASK   = 8'h84;
    localparam logic [21:0] IO_SPACE_HIGH = 22'h3FFFFF;

    // Active-low cathodes {dp,g,f,e,d,c,b,a}; dp is always off
    localparam logic [7:0] HEX_CAT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [2:0] {
        SEL_LED,
        SEL_SW,
        SEL_SEG_VAL,
        SEL_SEG_MASK,
        SEL_NONE
    } io_sel_e;

    function automatic io_sel_e io_decode(input logic [7:0] addr);
        case (addr)
            IO_LED:      return SEL_LED;
            IO_SW:       return SEL_SW;
            IO_SEG_VAL:  return SEL_SEG_VAL;
            IO_SEG_MASK: return SEL_SEG_MASK;
            default:     return SEL_NONE;
        endcase
    endfunction

    function automatic logic [7:0] hex_to_cat(input logic [3:0] nib);
        return HEX_CAT[nib];
    endfunction

endpackage

// File: rtl/io_bridge_switch_debouncer.sv
// Two-flop synchronizer plus saturating-counter debouncer for the board switches.
module switch_debouncer #(
    parameter int unsigned WIDTH           = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw_i,
    output logic [WIDTH-1:0] sw_stable_o
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta_q, sync_q, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // meta_q is the sample sync_q takes next, so a change clears the count on
    // the same edge the synchronized vector changes
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (meta_q != sync_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LOAD) stable_d = sync_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            meta_q   <= sw_raw_i;
            sync_q   <= meta_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign sw_stable_o = stable_q;

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped I/O stage: LED, debounced switches, scanned 8-digit display,
// and the lw writeback mux between data memory and I/O.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned SW_WIDTH        = 24,
    parameter int unsigned LED_WIDTH       = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 MemRead,
    input  logic                 IORead,
    input  logic                 IOWrite,
    input  logic [7:0]           addr_low,
    input  logic [31:0]          write_data,
    input  logic [31:0]          mem_rdata,
    input  logic [SW_WIDTH-1:0]  switch_in,
    output logic [31:0]          r_wdata,
    output logic [LED_WIDTH-1:0] led_out,
    output logic [7:0]           seg_an,
    output logic [7:0]           seg_cat,
    output logic                 io_err
);

    localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [LED_WIDTH-1:0] led_q;
    logic [31:0]          seg_val_q;
    logic [7:0]           seg_mask_q;
    logic                 io_err_q, io_err_d;
    logic [DIV_W-1:0]     div_q;
    logic [2:0]           idx_q;
    logic [7:0]           an_q, an_d, cat_q, cat_d;
    logic [SW_WIDTH-1:0]  sw_stable;
    io_sel_e              sel;

    switch_debouncer #(
        .WIDTH          (SW_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock      (clock),
        .reset      (reset),
        .sw_raw_i   (switch_in),
        .sw_stable_o(sw_stable)
    );

    assign sel = io_decode(addr_low);

    always_comb begin
        r_wdata = '0;
        if (MemRead) begin
            r_wdata = mem_rdata;
        end else if (IORead) begin
            case (sel)
                SEL_LED:      r_wdata = 32'(led_q);
                SEL_SW:       r_wdata = 32'(sw_stable);
                SEL_SEG_VAL:  r_wdata = seg_val_q;
                SEL_SEG_MASK: r_wdata = {24'h0, seg_mask_q};
                default:      r_wdata = '0;
            endcase
        end
    end

    // Writes to the read-only switch register count as illegal accesses
    always_comb begin
        io_err_d = 1'b0;
        if (IOWrite)     io_err_d = (sel == SEL_NONE) || (sel == SEL_SW);
        else if (IORead) io_err_d = (sel == SEL_NONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_q      <= '0;
            seg_val_q  <= '0;
            seg_mask_q <= '0;
            io_err_q   <= 1'b0;
        end else begin
            io_err_q <= io_err_d;
            if (IOWrite) begin
                case (sel)
                    SEL_LED:      led_q      <= write_data[LED_WIDTH-1:0];
                    SEL_SEG_VAL:  seg_val_q  <= write_data;
                    SEL_SEG_MASK: seg_mask_q <= write_data[7:0];
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        an_d  = '1;
        cat_d = '1;
        if (seg_mask_q[idx_q]) begin
            an_d  = ~(8'h01 << idx_q);
            cat_d = hex_to_cat(seg_val_q[{idx_q, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            cat_q <= '1;
        end else begin
            an_q  <= an_d;
            cat_q <= cat_d;
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign led_out = led_q;
    assign seg_an  = an_q;
    assign seg_cat = cat_q;
    assign io_err  = io_err_q;

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge with a cycle-level behavioural model checked on every falling edge.
module tb_io_bridge;

    localparam int DEB  = 4;
    localparam int SCAN = 2;

    localparam logic [7:0] CAT_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clock = 1'b0;
    logic        reset, MemRead, IORead, IOWrite;
    logic [7:0]  addr_low;
    logic [31:0] write_data, mem_rdata;
    logic [23:0] switch_in;
    logic [31:0] r_wdata;
    logic [23:0] led_out;
    logic [7:0]  seg_an, seg_cat;
    logic        io_err;

    int errors = 0;
    int checks = 0;

    io_bridge #(
        .DEBOUNCE_CYCLES(DEB),
        .SCAN_DIV       (SCAN),
        .SW_WIDTH       (24),
        .LED_WIDTH      (24)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .IORead    (IORead),
        .IOWrite   (IOWrite),
        .addr_low  (addr_low),
        .write_data(write_data),
        .mem_rdata (mem_rdata),
        .switch_in (switch_in),
        .r_wdata   (r_wdata),
        .led_out   (led_out),
        .seg_an    (seg_an),
        .seg_cat   (seg_cat),
        .io_err    (io_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents plus a history of sampled switch values
    bit          m_valid = 0;
    logic [23:0] m_led, m_stable;
    logic [31:0] m_val;
    logic [7:0]  m_mask, m_an, m_cat;
    logic        m_err;
    int          m_edges;
    logic [23:0] hist [$];

    function automatic bit mapped_rd(input logic [7:0] a);
        return (a == 8'h60) || (a == 8'h70) || (a == 8'h80) || (a == 8'h84);
    endfunction

    function automatic bit mapped_wr(input logic [7:0] a);
        return (a == 8'h60) || (a == 8'h80) || (a == 8'h84);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_valid  = 1;
            m_led    = '0;
            m_val    = '0;
            m_mask   = '0;
            m_stable = '0;
            m_err    = 1'b0;
            m_an     = 8'hFF;
            m_cat    = 8'hFF;
            m_edges  = 0;
            hist.delete();
            hist.push_back(24'h0);
            hist.push_back(24'h0);
        end else begin
            int  digit;
            bit  same;
            digit = (m_edges / SCAN) % 8;
            if (m_mask[digit]) begin
                m_an  = ~(8'h01 << digit);
                m_cat = CAT_TAB[(m_val >> (4 * digit)) & 32'hF];
            end else begin
                m_an  = 8'hFF;
                m_cat = 8'hFF;
            end
            m_edges++;
            m_err = (IOWrite && !mapped_wr(addr_low)) ||
                    (!IOWrite && IORead && !mapped_rd(addr_low));
            if (IOWrite) begin
                if (addr_low == 8'h60) m_led  = write_data[23:0];
                if (addr_low == 8'h80) m_val  = write_data;
                if (addr_low == 8'h84) m_mask = write_data[7:0];
            end
            // Accepted once DEB+1 consecutive samples agree, seen through the synchronizer delay
            if (hist.size() >= DEB + 1) begin
                same = 1;
                for (int k = 1; k <= DEB; k++)
                    if (hist[hist.size() - 1 - k] != hist[hist.size() - 1]) same = 0;
                if (same) m_stable = hist[hist.size() - 1];
            end
            hist.push_back(switch_in);
            if (hist.size() > 16) void'(hist.pop_front());
        end
    end

    function automatic logic [31:0] exp_rdata();
        if (MemRead) return mem_rdata;
        if (!IORead) return 32'h0;
        case (addr_low)
            8'h60:   return {8'h0, m_led};
            8'h70:   return {8'h0, m_stable};
            8'h80:   return m_val;
            8'h84:   return {24'h0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clock) begin
        if (m_valid) begin
            chk("m_r_wdata", r_wdata, exp_rdata());
            chk("m_led_out", 32'(led_out), 32'(m_led));
            chk("m_seg_an", 32'(seg_an), 32'(m_an));
            chk("m_seg_cat", 32'(seg_cat), 32'(m_cat));
            chk("m_io_err", 32'(io_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [31:0] d);
        addr_low   = a;
        write_data = d;
        IOWrite    = 1'b1;
        tick();
        IOWrite    = 1'b0;
    endtask

    int n_d0, n_d1, n_off;

    initial begin
        reset = 1'b1; MemRead = 1'b0; IORead = 1'b0; IOWrite = 1'b0;
        addr_low = 8'h0; write_data = 32'h0; mem_rdata = 32'h0; switch_in = 24'h0;
        tick();
        tick();
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_an", 32'(seg_an), 32'hFF);
        chk("rst_cat", 32'(seg_cat), 32'hFF);
        chk("rst_err", 32'(io_err), 32'h0);
        reset = 1'b0;

        io_wr(8'h60, 32'h00ABCDEF);
        chk("led_wr", 32'(led_out), 32'h00ABCDEF);
        IORead = 1'b1; addr_low = 8'h60; #1;
        chk("led_rd", r_wdata, 32'h00ABCDEF);
        tick();

        switch_in = 24'h000005; addr_low = 8'h70;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("sw_latency", r_wdata, (i == 6) ? 32'h5 : 32'h0);
        end
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) switch_in = switch_in ^ 24'h00000F;
            tick();
            chk("sw_toggle", r_wdata, 32'h5);
        end
        IORead = 1'b0;

        io_wr(8'h80, 32'h876543F0);
        io_wr(8'h84, 32'h00000003);
        tick();
        n_d0 = 0; n_d1 = 0; n_off = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (seg_an == 8'hFE) begin
                n_d0++;
                chk("dig0_cat", 32'(seg_cat), 32'hC0);
            end else if (seg_an == 8'hFD) begin
                n_d1++;
                chk("dig1_cat", 32'(seg_cat), 32'h8E);
            end else begin
                n_off++;
                chk("off_an", 32'(seg_an), 32'hFF);
                chk("off_cat", 32'(seg_cat), 32'hFF);
            end
        end
        chk("n_dig0", 32'(n_d0), 32'd2);
        chk("n_dig1", 32'(n_d1), 32'd2);
        chk("n_off", 32'(n_off), 32'd12);

        io_wr(8'h44, 32'hFFFFFFFF);
        chk("err_wr44", 32'(io_err), 32'h1);
        chk("led_keep44", 32'(led_out), 32'h00ABCDEF);
        tick();
        chk("err_clr44", 32'(io_err), 32'h0);
        io_wr(8'h70, 32'h12345678);
        chk("err_wr70", 32'(io_err), 32'h1);
        tick();
        chk("err_clr70", 32'(io_err), 32'h0);
        IORead = 1'b1; addr_low = 8'h44; #1;
        chk("rd44_data", r_wdata, 32'h0);
        tick();
        chk("err_rd44", 32'(io_err), 32'h1);
        addr_low = 8'h84; #1;
        chk("mask_keep", r_wdata, 32'h3);
        addr_low = 8'h80; #1;
        chk("val_keep", r_wdata, 32'h876543F0);
        IORead = 1'b0;
        tick();

        MemRead = 1'b1; mem_rdata = 32'hDEADBEEF; addr_low = 8'h44; #1;
        chk("mem_rd44", r_wdata, 32'hDEADBEEF);
        tick();
        chk("mem_noerr", 32'(io_err), 32'h0);
        addr_low = 8'h60; #1;
        chk("mem_rd60", r_wdata, 32'hDEADBEEF);
        tick();
        MemRead = 1'b0;

        io_wr(8'h84, 32'h000000FF);
        switch_in = 24'h000123;
        tick();
        tick();
        reset = 1'b1;
        IOWrite = 1'b1; addr_low = 8'h60; write_data = 32'h00000001;
        tick();
        chk("rst2_led", 32'(led_out), 32'h0);
        chk("rst2_an", 32'(seg_an), 32'hFF);
        chk("rst2_cat", 32'(seg_cat), 32'hFF);
        chk("rst2_err", 32'(io_err), 32'h0);
        reset = 1'b0; IOWrite = 1'b0;
        IORead = 1'b1; addr_low = 8'h70; #1;
        chk("rst2_sw", r_wdata, 32'h0);
        addr_low = 8'h84; #1;
        chk("rst2_mask", r_wdata, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        IORead = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Memory-mapped I/O stage directly downstream of the CPU control unit.
- Consumes the control unit's MemRead, IORead and IOWrite strobes plus the low ALU-result address bits.
- Owns the board peripherals: a LED register, a debounced switch input and a scanned 8-digit 7-segment display.
- Supplies the register-file writeback data for lw, chosen between data memory and I/O.

Parameters:
- DEBOUNCE_CYCLES, 100000, cycles the synchronized switch vector must hold constant before it is accepted.
- SCAN_DIV, 50000, clock cycles each display digit stays lit.
- SW_WIDTH, 24, number of switch inputs.
- LED_WIDTH, 24, number of LED outputs.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  lw to data memory (from control unit).
- IORead  in  1  lw to I/O space (from control unit).
- IOWrite  in  1  sw to I/O space (from control unit).
- addr_low  in  8  ALU result [7:0]; I/O space is 0xFFFFFC00-0xFFFFFFFF.
- write_data  in  32  register rt value for sw.
- mem_rdata  in  32  data-memory read data.
- switch_in  in  SW_WIDTH  raw asynchronous board switches.
- r_wdata  out  32  writeback data to the register file.
- led_out  out  LED_WIDTH  LED register contents.
- seg_an  out  8  digit anodes, active-low.
- seg_cat  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- io_err  out  1  one-cycle pulse on an access to an unmapped I/O address.

Behaviour:
- Register map (addr_low):
  - 0x60 LED: R/W, LED_WIDTH bits.
  - 0x70 switches: R only, stable value zero-extended.
  - 0x80 seg_value: R/W, 32 bits = 8 hex digits, digit 0 = [3:0].
  - 0x84 seg_mask: R/W, bits [7:0]; bit i enables digit i.
  - Any other offset is unmapped.
- r_wdata is combinational:
  - MemRead=1: mem_rdata.
  - Else IORead=1: the selected register value, or 0 if unmapped.
  - Else 0.
  - MemRead and IORead both 1 cannot occur; MemRead takes priority.
- Writes commit on the rising edge while IOWrite=1, because the CPU is single-cycle.
  - Upper unused bits of write_data are discarded.
  - A write to 0x70 is ignored.
  - A write to 0x70 or to an unmapped offset raises io_err on the next cycle.
- io_err: registered, high for exactly the one cycle after an IORead or IOWrite cycle whose address was unmapped or illegal.
- Switch path:
  - 2-flop synchronizer, then a debouncer.
  - Counter clears whenever the synchronized vector differs from the previous synchronized sample; otherwise it increments, saturating at DEBOUNCE_CYCLES.
  - When the counter equals DEBOUNCE_CYCLES-1 and increments, the stable register loads the synchronized vector.
  - Accepted latency is 2 synchronizer cycles + DEBOUNCE_CYCLES.
- Display scan:
  - div_cnt counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and digit_idx advances 0..7, with 7 wrapping to 0.
  - seg_an and seg_cat are registered.
  - seg_an is all ones except bit digit_idx = 0 when seg_mask[digit_idx]=1.
  - seg_cat is the hex pattern of nibble digit_idx, with dp=1 (off).
  - When the digit is masked off, seg_an = 8'hFF and seg_cat = 8'hFF.
  - Pattern examples: 0 -> 8'hC0, 8 -> 8'h80, F -> 8'h8E.
- Reset values:
  - led_out, seg_value, seg_mask, stable switches, synchronizers, counters, digit_idx: 0.
  - seg_an = 8'hFF, seg_cat = 8'hFF, io_err = 0.
- Reset asserted mid-debounce or mid-scan returns everything to reset values on that edge. Writes in the same cycle as reset are lost.

Decomposition:
- Shared package holds:
  - Address offsets: IO_LED=8'h60, IO_SW=8'h70, IO_SEG_VAL=8'h80, IO_SEG_MASK=8'h84.
  - IO_SPACE_HIGH=22'h3FFFFF.
  - The 16-entry hex-to-cathode constant table.
- One sub-module, switch_debouncer: synchronizer, counter and stable register, parameterized by width and DEBOUNCE_CYCLES.

Test Plan:
- Reset, then IOWrite to 0x60 with write_data=32'h00ABCDEF -> led_out=24'hABCDEF the next cycle; IORead at 0x60 -> r_wdata=32'h00ABCDEF.
- With DEBOUNCE_CYCLES=4: switch_in=24'h000005 held -> IORead at 0x70 reads 0 until 6 cycles after the change, then 32'h00000005. Toggling the input every 2 cycles never updates the stable value.
- With SCAN_DIV=2, seg_value=32'h8765_43F0, seg_mask=8'h03:
  - digit 0: seg_an=8'hFE, seg_cat=8'hC0.
  - digit 1: seg_an=8'hFD, seg_cat=8'h8E.
  - digits 2-7: seg_an=8'hFF.
  - After 16 cycles digit_idx wraps to 0.
- IOWrite at 0x44 and at 0x70 -> io_err pulses one cycle each; LED and seg registers unchanged. IORead at 0x44 -> r_wdata=0 and io_err pulse.
- MemRead=1 with mem_rdata=32'hDEADBEEF -> r_wdata=32'hDEADBEEF regardless of addr_low; no io_err.
- Assert reset during a scan and a debounce with seg_mask=8'hFF -> next cycle all outputs at reset values: seg_an=8'hFF, led_out=0.
